// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and decodes datapath controls
// from the registered state. It also counts retired instructions and latches fault codes.
module multicycle_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic             Zf,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [2:0]       ALU_op,
  output logic             regDst,
  output logic             Demuxo,
  output logic             BRWe,
  output logic             ReMD,
  output logic             WeMD,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       fault
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd15
  } state_t;

  state_t             state_q;
  logic [5:0]         op_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   count_q;
  logic [1:0]         fault_q;

  // Sequencing, memory wait tracking, retire counter and fault latch
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      op_q     <= 6'd0;
      wait_cnt <= '0;
      count_q  <= '0;
      fault_q  <= FAULT_NONE;
    end else begin
      case (state_q)
        FETCH: state_q <= DECODE;
        DECODE: begin
          op_q <= Op;
          case (Op)
            OP_RTYPE:                         state_q <= EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_q <= EXEC_I;
            OP_LW, OP_SW:                     state_q <= MEM_ADDR;
            OP_BEQ:                           state_q <= BRANCH;
            OP_J:                             state_q <= JUMP;
            default: begin
              state_q <= HALT;
              fault_q <= FAULT_ILLEGAL;
            end
          endcase
        end
        EXEC_R, EXEC_I: state_q <= WB_ALU;
        MEM_ADDR: state_q <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD, MEM_WR: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state_q == MEM_RD) begin
              state_q <= WB_MEM;
            end else begin
              state_q <= FETCH;
              count_q <= count_q + CNT_W'(1);
            end
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            wait_cnt <= '0;
            state_q  <= HALT;
            fault_q  <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        WB_ALU, WB_MEM, BRANCH, JUMP: begin
          state_q <= FETCH;
          count_q <= count_q + CNT_W'(1);
        end
        HALT: state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  // Moore decode of datapath controls; reset masks everything but the state code
  always_comb begin
    pc_we   = 1'b0;
    pc_src  = 2'b00;
    ir_we   = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = 2'b00;
    ALU_op  = 3'b000;
    regDst  = 1'b0;
    Demuxo  = 1'b0;
    BRWe    = 1'b0;
    ReMD    = 1'b0;
    WeMD    = 1'b0;
    if (!RST) begin
      case (state_q)
        FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          aluSrcB = 2'b01;
        end
        DECODE: aluSrcB = 2'b11;
        EXEC_R: begin
          aluSrcA = 1'b1;
          ALU_op  = 3'b010;
        end
        EXEC_I: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          case (op_q)
            OP_ANDI: ALU_op = 3'b101;
            OP_ORI:  ALU_op = 3'b100;
            OP_SLTI: ALU_op = 3'b011;
            default: ALU_op = 3'b000;
          endcase
        end
        MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        MEM_RD: ReMD = 1'b1;
        MEM_WR: WeMD = 1'b1;
        WB_ALU: begin
          BRWe   = 1'b1;
          Demuxo = 1'b1;
          regDst = (op_q == OP_RTYPE);
        end
        WB_MEM: BRWe = 1'b1;
        BRANCH: begin
          aluSrcA = 1'b1;
          ALU_op  = 3'b001;
          pc_src  = 2'b01;
          pc_we   = Zf;
        end
        JUMP: begin
          pc_src = 2'b10;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = RST ? '0 : count_q;
  assign fault       = RST ? FAULT_NONE : fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: expected state walks and controls come from an
// instruction-level model that expands each opcode into its state sequence.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 5;

  logic             CLK = 1'b0;
  logic             RST;
  logic [5:0]       Op;
  logic             Zf;
  logic             mem_ready;
  logic             pc_we, ir_we, aluSrcA, regDst, Demuxo, BRWe, ReMD, WeMD;
  logic [1:0]       pc_src, aluSrcB, fault;
  logic [2:0]       ALU_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int passes = 0;
  int model_cnt = 0;

  multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zf(Zf), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .ALU_op(ALU_op), .regDst(regDst), .Demuxo(Demuxo), .BRWe(BRWe), .ReMD(ReMD), .WeMD(WeMD),
    .state(state), .instr_count(instr_count), .fault(fault)
  );

  always #5 CLK = ~CLK;

  wire [14:0] act_ctl = {pc_we, ir_we, BRWe, ReMD, WeMD, regDst, Demuxo,
                         aluSrcA, aluSrcB, pc_src, ALU_op};

  // Control table per state, written from the instruction-step descriptions
  function automatic logic [14:0] exp_ctl(input int st, input logic [5:0] op, input logic zf);
    logic pw, iw, bw, rd, wr, rdst, dmx, asa;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {pw, iw, bw, rd, wr, rdst, dmx, asa} = 8'd0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      0: begin iw = 1; pw = 1; asb = 2'b01; end
      1: asb = 2'b11;
      2: begin asa = 1; alu = 3'b010; end
      3: begin
        asa = 1; asb = 2'b10;
        if (op == 6'd12) alu = 3'b101;
        else if (op == 6'd13) alu = 3'b100;
        else if (op == 6'd10) alu = 3'b011;
      end
      4: begin asa = 1; asb = 2'b10; end
      5: rd = 1;
      6: wr = 1;
      7: begin bw = 1; dmx = 1; rdst = (op == 6'd0); end
      8: bw = 1;
      9: begin asa = 1; alu = 3'b001; pcs = 2'b01; pw = zf; end
      10: begin pcs = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, iw, bw, rd, wr, rdst, dmx, asa, asb, pcs, alu};
  endfunction

  // Runs one instruction from FETCH; w = wait cycles before mem_ready (w > TMO forces timeout)
  task automatic run_instr(input logic [5:0] op, input int w, input logic zf);
    int seq[$];
    int mem_seen = 0;
    int exp_fault = 0;
    bit retire = 1;
    int n = (w > TMO) ? int'(TMO) + 1 : w + 1;
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'd0: begin seq.push_back(2); seq.push_back(7); end
      6'd8, 6'd12, 6'd13, 6'd10: begin seq.push_back(3); seq.push_back(7); end
      6'd35, 6'd43: begin
        seq.push_back(4);
        repeat (n) seq.push_back(op == 6'd35 ? 5 : 6);
        if (w > TMO) begin seq.push_back(15); retire = 0; exp_fault = 2; end
        else if (op == 6'd35) seq.push_back(8);
      end
      6'd4: seq.push_back(9);
      6'd2: seq.push_back(10);
      default: begin seq.push_back(15); retire = 0; exp_fault = 1; end
    endcase
    foreach (seq[i]) begin
      Op = op;
      Zf = zf;
      mem_ready = (seq[i] == 5 || seq[i] == 6) && (mem_seen == w);
      if (seq[i] == 5 || seq[i] == 6) mem_seen++;
      #1;
      checks++;
      if (state !== 4'(seq[i]))
        $display("FAIL state op=%b step=%0d: got %0d want %0d", op, i, state, seq[i]);
      else passes++;
      checks++;
      if (act_ctl !== exp_ctl(seq[i], op, zf))
        $display("FAIL ctl op=%b step=%0d state=%0d: got %b want %b",
                 op, i, seq[i], act_ctl, exp_ctl(seq[i], op, zf));
      else passes++;
      @(posedge CLK); #1;
    end
    if (retire) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (instr_count !== CNT_W'(model_cnt))
      $display("FAIL count op=%b: got %0d want %0d", op, instr_count, model_cnt);
    else passes++;
    checks++;
    if (fault !== 2'(exp_fault))
      $display("FAIL fault op=%b: got %b want %0d", op, fault, exp_fault);
    else passes++;
    checks++;
    if (state !== (retire ? 4'd0 : 4'd15))
      $display("FAIL next_state op=%b: got %0d want %0d", op, state, retire ? 0 : 15);
    else passes++;
    if (!retire) begin
      // HALT must be sticky with all strobes low and the counter frozen
      repeat (3) begin
        @(posedge CLK); #1;
        mem_ready = 1'b1;
        checks++;
        if (state !== 4'd15 || act_ctl !== 15'd0 || instr_count !== CNT_W'(model_cnt))
          $display("FAIL halt_hold: got state=%0d ctl=%b cnt=%0d want 15/0/%0d",
                   state, act_ctl, instr_count, model_cnt);
        else passes++;
      end
      #1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; Op = 6'd0; Zf = 1'b1; mem_ready = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (state !== 4'd0 || act_ctl !== 15'd0 || instr_count !== '0 || fault !== 2'b00)
      $display("FAIL reset_hold: got state=%0d ctl=%b cnt=%0d fault=%b want 0/0/0/0",
               state, act_ctl, instr_count, fault);
    else passes++;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    model_cnt = 0;
    checks++;
    if (state !== 4'd0 || act_ctl !== exp_ctl(0, 6'd0, 1'b0) || instr_count !== '0 || fault !== 2'b00)
      $display("FAIL reset_release: got state=%0d ctl=%b cnt=%0d fault=%b", state, act_ctl,
               instr_count, fault);
    else passes++;
  endtask

  task automatic test_r_type();
    run_instr(6'd0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    run_instr(6'd35, 3, 1'b0);
    run_instr(6'd35, 0, 1'b1);
    run_instr(6'd43, int'(TMO), 1'b0);
  endtask

  task automatic test_branch_jump();
    run_instr(6'd4, 0, 1'b1);
    run_instr(6'd4, 0, 1'b0);
    run_instr(6'd2, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops [9] = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd10, 6'd35, 6'd43, 6'd4, 6'd2};
    repeat (25) begin
      run_instr(ops[$urandom_range(0, 8)], int'($urandom_range(0, TMO)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_sw_timeout();
    run_instr(6'd43, int'(TMO) + 1, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0, 1'b0);
  endtask

  task automatic test_reset_mid_mem();
    Op = 6'd35; Zf = 1'b0; mem_ready = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    checks++;
    if (state !== 4'd5 || ReMD !== 1'b1)
      $display("FAIL mid_mem_pre: got state=%0d ReMD=%b want 5/1", state, ReMD);
    else passes++;
    RST = 1'b1;
    #1;
    checks++;
    if (ReMD !== 1'b0) $display("FAIL mid_mem_remd: got %b want 0", ReMD);
    else passes++;
    @(posedge CLK); #1;
    checks++;
    if (state !== 4'd0 || act_ctl !== 15'd0)
      $display("FAIL mid_mem_reset: got state=%0d ctl=%b want 0/0", state, act_ctl);
    else passes++;
    RST = 1'b0;
    model_cnt = 0;
    #1;
  endtask

  task automatic test_count_wrap();
    repeat (17) run_instr(6'd0, 0, 1'b0);
    checks++;
    if (instr_count !== CNT_W'(1)) $display("FAIL wrap: got %0d want 1", instr_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch_jump();
    test_random();
    test_sw_timeout();
    test_reset();
    test_illegal();
    test_reset();
    test_reset_mid_mem();
    test_count_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
